// File: rtl/gpr_wb_if.sv
// Writeback-stage bundle: ALU and load-return requests in, GPR write port,
// per-read-port bypass and load-pending flags out.
interface gpr_wb_if #(parameter int LDQ_DEPTH = 4);
    localparam int CW = $clog2(LDQ_DEPTH) + 1;

    logic          alu_val;
    logic [4:0]    alu_adr;
    logic [31:0]   alu_dat;
    logic          alu_rdy;
    logic          ld_val;
    logic [4:0]    ld_adr;
    logic [31:0]   ld_dat;
    logic          ld_rdy;
    logic [4:0]    rd_adr_0, rd_adr_1, rd_adr_2;
    logic          byp_hit_0, byp_hit_1, byp_hit_2;
    logic [31:0]   byp_dat_0, byp_dat_1, byp_dat_2;
    logic          ld_pend_0, ld_pend_1, ld_pend_2;
    logic          wr_en_0;
    logic [4:0]    wr_adr_0;
    logic [31:0]   wr_dat_0;
    logic [CW-1:0] ldq_cnt;

    modport master (
        output alu_val, alu_adr, alu_dat, ld_val, ld_adr, ld_dat,
               rd_adr_0, rd_adr_1, rd_adr_2,
        input  alu_rdy, ld_rdy, byp_hit_0, byp_hit_1, byp_hit_2,
               byp_dat_0, byp_dat_1, byp_dat_2, ld_pend_0, ld_pend_1, ld_pend_2,
               wr_en_0, wr_adr_0, wr_dat_0, ldq_cnt
    );

    modport slave (
        input  alu_val, alu_adr, alu_dat, ld_val, ld_adr, ld_dat,
               rd_adr_0, rd_adr_1, rd_adr_2,
        output alu_rdy, ld_rdy, byp_hit_0, byp_hit_1, byp_hit_2,
               byp_dat_0, byp_dat_1, byp_dat_2, ld_pend_0, ld_pend_1, ld_pend_2,
               wr_en_0, wr_adr_0, wr_dat_0, ldq_cnt
    );
endinterface

// File: rtl/gpr_wb.sv
// GPR writeback stage: merges ALU results and FIFO-buffered load returns into
// one registered GPR write per cycle, with bypass and load-pending lookups.
module gpr_wb #(
    parameter int LDQ_DEPTH = 4
) (
    input logic   clk,
    input logic   rst_n,
    gpr_wb_if.slave wb
);
    localparam int PW  = $clog2(LDQ_DEPTH);
    localparam int CW  = PW + 1;
    localparam int NRD = 3;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
    } wb_req_t;

    wb_req_t          ldq [LDQ_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    cnt;
    logic             full, empty, push, pop, sel_vld;
    wb_req_t          win, wr_q;
    logic             wr_en;
    logic [LDQ_DEPTH-1:0] ent_vld;

    assign full  = (cnt == CW'(LDQ_DEPTH));
    assign empty = (cnt == '0);

    // A full queue preempts the ALU; otherwise the ALU wins over queued loads.
    // A push into an empty queue is not visible to pop until the next cycle.
    assign pop     = full || (!wb.alu_val && !empty);
    assign sel_vld = pop || wb.alu_val;
    assign win     = pop ? ldq[rd_ptr] : wb_req_t'({wb.alu_adr, wb.alu_dat});

    assign wb.alu_rdy = !full;
    assign wb.ld_rdy  = !full || pop;
    assign push       = wb.ld_val && wb.ld_rdy;

    always_ff @(posedge clk) begin
        if (push) ldq[wr_ptr] <= wb_req_t'({wb.ld_adr, wb.ld_dat});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Address/data hold their last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en <= 1'b0;
            wr_q  <= '0;
        end else begin
            wr_en <= sel_vld;
            if (sel_vld) wr_q <= win;
        end
    end

    assign wb.wr_en_0  = wr_en;
    assign wb.wr_adr_0 = wr_q.adr;
    assign wb.wr_dat_0 = wr_q.dat;
    assign wb.ldq_cnt  = cnt;

    // Slot is live when its distance from the head is below the occupancy.
    for (genvar e = 0; e < LDQ_DEPTH; e++) begin : g_ent
        logic [PW-1:0] off;
        assign off        = PW'(e) - rd_ptr;
        assign ent_vld[e] = ({1'b0, off} < cnt);
    end

    logic [NRD-1:0][4:0] rd_adr;
    logic [NRD-1:0]      byp_hit, ld_pend;

    assign rd_adr = {wb.rd_adr_2, wb.rd_adr_1, wb.rd_adr_0};

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [LDQ_DEPTH-1:0] hit;
        for (genvar e = 0; e < LDQ_DEPTH; e++) begin : g_cmp
            assign hit[e] = ent_vld[e] && (ldq[e].adr == rd_adr[p]);
        end
        assign ld_pend[p] = |hit;
        assign byp_hit[p] = wr_en && (wr_q.adr == rd_adr[p]);
    end

    assign wb.byp_hit_0 = byp_hit[0];
    assign wb.byp_hit_1 = byp_hit[1];
    assign wb.byp_hit_2 = byp_hit[2];
    assign wb.byp_dat_0 = wr_q.dat;
    assign wb.byp_dat_1 = wr_q.dat;
    assign wb.byp_dat_2 = wr_q.dat;
    assign wb.ld_pend_0 = ld_pend[0];
    assign wb.ld_pend_1 = ld_pend[1];
    assign wb.ld_pend_2 = ld_pend[2];
endmodule
